instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset and after load completion.
REQ-002 Parameter HALT_WORD, default 32'hFFFF_FFFF: instruction word that stops fetching.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 load_done_i  input  1  level; instruction memory preload complete.
REQ-006 redirect_i  input  1  branch/jump redirect request.
REQ-007 redirect_addr_i  input  32  redirect target.
REQ-008 inst_addr_o  output  32  byte address to Instruction_Memory addr_i.
REQ-009 inst_i  input  32  Instruction_Memory instr_o; combinational read of inst_addr_o, same cycle.
REQ-010 if_valid_o  output  1  IF/ID payload valid.
REQ-011 if_ready_i  input  1  IF/ID accepts payload.
REQ-012 if_pc_o  output  32  PC of payload.
REQ-013 if_inst_o  output  32  instruction of payload.
REQ-014 halted_o  output  1  fetch stopped on HALT_WORD.

Function
REQ-015 The block SHALL implement states WAIT_LOAD, RUN, HALT; reset enters WAIT_LOAD.
REQ-016 WAIT_LOAD SHALL hold inst_addr_o = RESET_PC and if_valid_o = 0, moving to RUN on the first cycle load_done_i = 1.
REQ-017 In RUN, the output register SHALL load {inst_addr_o, inst_i} with if_valid_o = 1 when (!if_valid_o || if_ready_i), and the PC SHALL advance by 4 in the same cycle.
REQ-018 If the output register cannot load (if_valid_o && !if_ready_i), the PC and payload SHALL hold unchanged (stall).
REQ-019 Latency: an address presented in cycle N SHALL appear on if_pc_o/if_inst_o in cycle N+1.
REQ-020 Sustained throughput SHALL be one instruction per cycle while if_ready_i = 1.
REQ-021 PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 SHALL wrap to 32'h0000_0000.
REQ-022 redirect_i in RUN or HALT SHALL clear if_valid_o, set PC to {redirect_addr_i[31:2], 2'b00} next cycle, and enter RUN; redirect takes priority over stall and over HALT detection in the same cycle.
REQ-023 redirect_i in WAIT_LOAD SHALL be ignored.
REQ-024 When a word equal to HALT_WORD is loaded into the output register, state SHALL become HALT; that word is not presented (if_valid_o = 0), PC holds at the halt address, halted_o = 1.
REQ-025 In HALT, if_valid_o SHALL be 0 once the pending payload is accepted; a payload present at halt entry SHALL remain valid until handshaken.
REQ-026 load_done_i falling in RUN or HALT SHALL have no effect.

Reset
REQ-027 On reset: inst_addr_o = RESET_PC, if_valid_o = 0, if_pc_o = 0, if_inst_o = 0, halted_o = 0, state WAIT_LOAD.
REQ-028 Reset asserted mid-stream SHALL discard the pending payload and take priority over redirect and handshake.

Configuration
REQ-029 Macro INSTR_FETCH_PERF_CNT_EN: when defined, add output fetch_cnt_o (32) counting accepted payloads (if_valid_o && if_ready_i), reset to 0, cleared by nothing else, wrapping at 2^32; when undefined, the port and counter SHALL not exist and behaviour is otherwise identical.

Structure
REQ-030 A shared package SHALL hold the state enum (WAIT_LOAD, RUN, HALT), the PC increment constant (4), and the default RESET_PC/HALT_WORD values.
REQ-031 Sub-module if_out_reg SHALL hold the valid/ready payload register; PC and FSM stay in instr_fetch.

Verification
REQ-032 Reset, load_done_i = 1 at cycle 3, if_ready_i = 1 -> inst_addr_o 0,4,8,... from cycle 3; if_pc_o = 0 in cycle 4.
REQ-033 Payload at PC 8, if_ready_i low 3 cycles -> if_pc_o/if_inst_o held at 8 for 3 cycles, inst_addr_o held at 12, resumes with 12.
REQ-034 redirect_i with addr 32'h0000_0043 while stalled -> if_valid_o = 0 next cycle, inst_addr_o = 32'h40, then 32'h40 presented.
REQ-035 Memory word 32'hFFFF_FFFF at address 16 -> payloads 0..12 delivered, halted_o = 1, inst_addr_o held 16; redirect to 0 -> RUN resumes from 0.
REQ-036 PC forced via redirect to 32'hFFFF_FFFC -> next inst_addr_o = 0.
REQ-037 With INSTR_FETCH_PERF_CNT_EN, 10 accepted payloads plus 2 stalled cycles -> fetch_cnt_o = 10.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    WAIT_LOAD = 2'd0,
    RUN       = 2'd1,
    HALT      = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_INC            = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/instr_fetch_if_out_reg.sv
// IF/ID payload register with a valid/ready handshake.
// A flush drops the payload; a load captures a new one (or an empty slot
// when the fetched word must not be presented); otherwise an accepted
// payload empties the slot and an unaccepted one is held.
module if_out_reg
  import instr_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        flush,
  input  logic        ready,
  input  logic        next_valid,
  input  logic [31:0] next_pc,
  input  logic [31:0] next_inst,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] inst
);

  // Payload slot update: reset, then flush, then load, then consume on handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      pc    <= 32'h0000_0000;
      inst  <= 32'h0000_0000;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= next_valid;
      if (next_valid) begin
        pc   <= next_pc;
        inst <= next_inst;
      end
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, WAIT_LOAD/RUN/HALT control and
// the IF/ID payload register. Instruction memory is read combinationally
// at inst_addr_o, so a fetched word is registered one cycle later.
// Optional feature: define INSTR_FETCH_PERF_CNT_EN to add fetch_cnt_o,
// a free-running count of accepted payloads.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_done_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic [31:0] inst_addr_o,
  input  logic [31:0] inst_i,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        halted_o
`ifdef INSTR_FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o
`endif
);

  fetch_state_e state, state_next;
  logic [31:0]  pc, pc_next;
  logic         fetch_en;
  logic         load_en;
  logic         load_valid;
  logic         flush;
  logic         hit_halt;
  logic         unused_addr_lsb;

  // Redirect targets are word aligned, so the byte offset bits are dropped
  assign unused_addr_lsb = ^redirect_addr_i[1:0];

  assign inst_addr_o = pc;
  assign halted_o    = (state == HALT);
  assign hit_halt    = (inst_i == HALT_WORD);
  assign load_valid  = !hit_halt;

  // State and PC registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT_LOAD;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // Next state, next PC and payload register control; redirect outranks stall and halt
  always_comb begin
    state_next = state;
    pc_next    = pc;
    fetch_en   = 1'b0;
    load_en    = 1'b0;
    flush      = 1'b0;
    case (state)
      WAIT_LOAD: begin
        if (load_done_i) begin
          state_next = RUN;
          fetch_en   = 1'b1;
        end
      end
      RUN:     fetch_en = 1'b1;
      HALT:    fetch_en = 1'b0;
      default: state_next = WAIT_LOAD;
    endcase
    if ((state != WAIT_LOAD) && redirect_i) begin
      flush      = 1'b1;
      pc_next    = {redirect_addr_i[31:2], 2'b00};
      state_next = RUN;
    end else if (fetch_en && (!if_valid_o || if_ready_i)) begin
      load_en = 1'b1;
      if (hit_halt) begin
        state_next = HALT;
      end else begin
        pc_next = pc + PC_INC;
      end
    end
  end

  if_out_reg u_if_out_reg (
    .clk        (clk),
    .reset      (reset),
    .load       (load_en),
    .flush      (flush),
    .ready      (if_ready_i),
    .next_valid (load_valid),
    .next_pc    (pc),
    .next_inst  (inst_i),
    .valid      (if_valid_o),
    .pc         (if_pc_o),
    .inst       (if_inst_o)
  );

`ifdef INSTR_FETCH_PERF_CNT_EN
  // Count every handshaken payload; only reset clears it
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_o <= 32'h0000_0000;
    end else if (if_valid_o && if_ready_i) begin
      fetch_cnt_o <= fetch_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed scenarios followed by randomized
// ready/redirect traffic. The reference model sees the program as a walk
// through memory from a start address to the first halt word; every
// accepted payload must be the next entry of the current walk.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] HALT     = 32'hFFFF_FFFF;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } payload_t;

  logic        clk;
  logic        reset;
  logic        load_done;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic [31:0] inst_addr;
  logic [31:0] inst;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        halted;
`ifdef INSTR_FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
`endif

  logic [31:0] mem [64];
  payload_t    exp_q [$];
  bit          loaded;
  int          checks;
  int          errors;
  int          acc_cnt;

  // Instruction memory: combinational read, aliased every 256 bytes
  assign inst = mem[inst_addr[7:2]];

  instr_fetch dut (
    .clk             (clk),
    .reset           (reset),
    .load_done_i     (load_done),
    .redirect_i      (redirect),
    .redirect_addr_i (redirect_addr),
    .inst_addr_o     (inst_addr),
    .inst_i          (inst),
    .if_valid_o      (if_valid),
    .if_ready_i      (if_ready),
    .if_pc_o         (if_pc),
    .if_inst_o       (if_inst),
    .halted_o        (halted)
`ifdef INSTR_FETCH_PERF_CNT_EN
    ,
    .fetch_cnt_o     (fetch_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Program-order stream from a start address up to (not including) the first halt word
  function automatic void push_walk(input logic [31:0] start);
    logic [31:0] a;
    a = {start[31:2], 2'b00};
    for (int i = 0; i < 64; i++) begin
      logic [31:0] w;
      w = mem[a[7:2]];
      if (w == HALT) break;
      exp_q.push_back('{pc: a, inst: w});
      a = a + 32'd4;
    end
  endfunction

  // At each edge the model reacts to the inputs held during the cycle that just ended,
  // then the next cycle's inputs are driven
  task automatic applyStimulus(input logic ld, input logic rdr, input logic [31:0] ra,
                               input logic rdy, input logic rst);
    @(posedge clk);
    if (reset) begin
      exp_q.delete();
      loaded = 1'b0;
    end else if (loaded && redirect) begin
      exp_q.delete();
      push_walk(redirect_addr);
    end else if (!loaded && load_done) begin
      loaded = 1'b1;
      push_walk(RESET_PC);
    end
    #1;
    load_done     = ld;
    redirect      = rdr;
    redirect_addr = ra;
    if_ready      = rdy;
    reset         = rst;
  endtask

  // Monitor: every handshaken payload must be the head of the expected stream
  always @(negedge clk) begin
    if (reset) begin
      acc_cnt = 0;
    end else if (if_valid && if_ready) begin
      acc_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_payload: got pc %h inst %h, expected no payload", if_pc, if_inst);
      end else begin
        payload_t e;
        e = exp_q.pop_front();
        checkOutput("sb_pc", if_pc, e.pc);
        checkOutput("sb_inst", if_inst, e.inst);
      end
    end
  end

  // Directed scenarios, random traffic, then drain to the final halt
  initial begin
    bit done;
    checks        = 0;
    errors        = 0;
    acc_cnt       = 0;
    loaded        = 1'b0;
    reset         = 1'b1;
    load_done     = 1'b0;
    redirect      = 1'b0;
    redirect_addr = 32'h0;
    if_ready      = 1'b1;
    for (int i = 0; i < 64; i++) begin
      logic [31:0] w;
      w = $urandom;
      if (w == HALT) w = 32'h0;
      mem[i] = w;
    end
    mem[4]  = HALT;
    mem[40] = HALT;

    applyStimulus(0, 0, 32'h0, 1, 1);
    applyStimulus(0, 0, 32'h0, 1, 1);
    @(negedge clk);
    checkOutput("reset_inst_addr", inst_addr, RESET_PC);
    checkOutput("reset_valid", {31'b0, if_valid}, 32'd0);
    checkOutput("reset_if_pc", if_pc, 32'h0);
    checkOutput("reset_if_inst", if_inst, 32'h0);
    checkOutput("reset_halted", {31'b0, halted}, 32'd0);

    // Redirect while waiting for the memory preload is ignored
    applyStimulus(0, 1, 32'h80, 1, 0);
    applyStimulus(0, 0, 32'h0, 1, 0);
    @(negedge clk);
    checkOutput("wait_redirect_addr", inst_addr, RESET_PC);
    checkOutput("wait_redirect_valid", {31'b0, if_valid}, 32'd0);

    // Load completes: addresses 0,4,8 and payload 0 one cycle later
    applyStimulus(1, 0, 32'h0, 1, 0);
    @(negedge clk);
    checkOutput("load_addr0", inst_addr, 32'h0);
    checkOutput("load_valid0", {31'b0, if_valid}, 32'd0);
    applyStimulus(1, 0, 32'h0, 1, 0);
    @(negedge clk);
    checkOutput("load_addr4", inst_addr, 32'h4);
    checkOutput("load_first_pc", if_pc, 32'h0);
    checkOutput("load_first_valid", {31'b0, if_valid}, 32'd1);
    applyStimulus(0, 0, 32'h0, 1, 0);
    @(negedge clk);
    checkOutput("load_addr8", inst_addr, 32'h8);

    // Stall three cycles on payload 8
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 32'h0, 0, 0);
      @(negedge clk);
      checkOutput("stall_pc", if_pc, 32'h8);
      checkOutput("stall_inst", if_inst, mem[2]);
      checkOutput("stall_addr", inst_addr, 32'hC);
    end
    applyStimulus(0, 0, 32'h0, 1, 0);
    applyStimulus(0, 0, 32'h0, 1, 0);
    @(negedge clk);
    checkOutput("resume_pc", if_pc, 32'hC);
    checkOutput("resume_addr", inst_addr, 32'h10);

    // Halt word at address 16
    applyStimulus(0, 0, 32'h0, 1, 0);
    applyStimulus(0, 0, 32'h0, 1, 0);
    @(negedge clk);
    checkOutput("halt_flag", {31'b0, halted}, 32'd1);
    checkOutput("halt_valid", {31'b0, if_valid}, 32'd0);
    checkOutput("halt_addr", inst_addr, 32'h10);
    checkOutput("halt_drained", exp_q.size(), 32'd0);

    // Redirect out of halt back to 0
    applyStimulus(0, 1, 32'h0, 1, 0);
    applyStimulus(0, 0, 32'h0, 1, 0);
    @(negedge clk);
    checkOutput("unhalt_flag", {31'b0, halted}, 32'd0);
    checkOutput("unhalt_addr", inst_addr, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 0);
    @(negedge clk);
    checkOutput("unhalt_first_pc", if_pc, 32'h0);
    applyStimulus(0, 0, 32'h0, 0, 0);

    // Redirect to an unaligned target while stalled
    applyStimulus(0, 1, 32'h43, 0, 0);
    applyStimulus(0, 0, 32'h0, 1, 0);
    @(negedge clk);
    checkOutput("redir_valid", {31'b0, if_valid}, 32'd0);
    checkOutput("redir_addr", inst_addr, 32'h40);
    applyStimulus(0, 0, 32'h0, 1, 0);
    @(negedge clk);
    checkOutput("redir_pc", if_pc, 32'h40);
    checkOutput("redir_inst", if_inst, mem[16]);

    // PC wraps from the top of the address space
    applyStimulus(0, 1, 32'hFFFF_FFFC, 1, 0);
    applyStimulus(0, 0, 32'h0, 1, 0);
    @(negedge clk);
    checkOutput("wrap_top_addr", inst_addr, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 32'h0, 1, 0);
    @(negedge clk);
    checkOutput("wrap_addr", inst_addr, 32'h0);
    checkOutput("wrap_pc", if_pc, 32'hFFFF_FFFC);

    // Reset mid-stream beats a simultaneous redirect and handshake
    applyStimulus(0, 1, 32'h20, 1, 1);
    applyStimulus(0, 0, 32'h0, 1, 0);
    @(negedge clk);
    checkOutput("midreset_valid", {31'b0, if_valid}, 32'd0);
    checkOutput("midreset_addr", inst_addr, RESET_PC);
    checkOutput("midreset_pc", if_pc, 32'h0);
    checkOutput("midreset_halted", {31'b0, halted}, 32'd0);

    // Random ready, redirect and load_done traffic
    applyStimulus(1, 0, 32'h0, 1, 0);
    for (int c = 0; c < 800; c++) begin
      applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0),
                    $urandom, ($urandom_range(0, 9) < 7), 0);
    end

    // Drain until the current walk reaches its halt word
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      applyStimulus(0, 0, 32'h0, 1, 0);
      @(negedge clk);
      if (halted) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got halted 0 after 200 cycles, expected halted 1");
    end
    applyStimulus(0, 0, 32'h0, 1, 0);
    @(negedge clk);
    checkOutput("final_halted", {31'b0, halted}, 32'd1);
    checkOutput("final_valid", {31'b0, if_valid}, 32'd0);
    checkOutput("final_drained", exp_q.size(), 32'd0);
`ifdef INSTR_FETCH_PERF_CNT_EN
    checkOutput("fetch_cnt", fetch_cnt, acc_cnt);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
